// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: prefetches RGB565 pixels for VGA scan-out and interleaves writer traffic.
// Optional macro VGA_ARB_UNDERFLOW_CNT_EN enables the saturating 16-bit underflow counter.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int FB_BASE    = 0,
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int WATERMARK  = 8
) (
  input  logic                          i_clk_25M,
  input  logic                          i_rst_n,
  input  logic                          i_frame_start,
  input  logic                          i_pix_rd,
  output logic [7:0]                    o_pix_r,
  output logic [7:0]                    o_pix_g,
  output logic [7:0]                    o_pix_b,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_frame_done,
  output logic                          o_underflow,
  output logic [15:0]                   o_underflow_cnt,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [15:0]                   i_wr_data,
  output logic [ADDR_W-1:0]             o_sram_addr,
  output logic                          o_sram_we_n,
  output logic                          o_sram_oe_n,
  output logic [15:0]                   o_sram_wdata,
  input  logic [15:0]                   i_sram_rdata
);

  localparam int TOTAL = H_ACT * V_ACT;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(TOTAL + 1);

  localparam logic [LVL_W:0]   DEPTH_C = (LVL_W+1)'(FIFO_DEPTH);
  localparam logic [LVL_W:0]   WM_C    = (LVL_W+1)'(WATERMARK);
  localparam logic [IDX_W-1:0] TOTAL_C = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(TOTAL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;

  logic [1:0]       r_state;
  logic             r_armed;
  logic [IDX_W-1:0] r_pix_idx;
  logic             r_inflight;
  logic [LVL_W-1:0] r_level;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [7:0]       r_pix_r;
  logic [7:0]       r_pix_g;
  logic [7:0]       r_pix_b;
  logic             r_frame_done;
  logic             r_underflow;

  logic [LVL_W:0]    w_occ;
  logic              w_rd_issue;
  logic              w_wr_go;
  logic              w_push;
  logic              w_pop_ok;
  logic              w_uflow;
  logic [15:0]       w_head;
  logic [ADDR_W-1:0] w_rd_addr;

  // A frame-start cycle never issues a read, so the fetch restarts cleanly at FB_BASE.
  assign w_occ      = {1'b0, r_level} + {{LVL_W{1'b0}}, r_inflight};
  assign w_rd_issue = (r_state == S_IDLE) && !i_frame_start && r_armed &&
                      (r_pix_idx < TOTAL_C) && (w_occ < DEPTH_C) &&
                      ((w_occ < WM_C) || !i_wr_valid);
  assign w_wr_go    = (r_state == S_IDLE) && !w_rd_issue && i_wr_valid;
  assign w_push     = r_inflight && !i_frame_start;
  assign w_pop_ok   = i_pix_rd && !i_frame_start && (r_level != '0);
  assign w_uflow    = i_pix_rd && !i_frame_start && (r_level == '0);
  assign w_head     = r_mem[r_rptr];
  assign w_rd_addr  = ADDR_W'(FB_BASE) + ADDR_W'(r_pix_idx);

  assign o_sram_we_n = (r_state != S_WR);
  assign o_sram_oe_n = !w_rd_issue;
  assign o_wr_ready  = (r_state == S_WR);

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (r_state == S_WR) begin
      o_sram_addr  = i_wr_addr;
      o_sram_wdata = i_wr_data;
    end else if (w_rd_issue) begin
      o_sram_addr  = w_rd_addr;
    end
  end

  // NOTE: pixel storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge i_clk_25M) begin
    if (w_push) r_mem[r_wptr] <= i_sram_rdata;
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_pix_idx    <= '0;
      r_inflight   <= 1'b0;
      r_level      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_pix_r      <= '0;
      r_pix_g      <= '0;
      r_pix_b      <= '0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_wr_go) r_state <= S_WR;
        S_WR:    r_state <= S_TURN;
        S_TURN:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (i_frame_start) begin
        r_armed      <= 1'b1;
        r_pix_idx    <= '0;
        r_inflight   <= 1'b0;
        r_level      <= '0;
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_frame_done <= 1'b0;
        r_underflow  <= 1'b0;
      end else begin
        r_inflight <= w_rd_issue;
        if (w_rd_issue) begin
          r_pix_idx <= r_pix_idx + IDX_W'(1);
          if (r_pix_idx == LAST_C) r_frame_done <= 1'b1;
        end
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        // Expand 5/6-bit channels by replicating their MSBs into the low bits.
        if (w_pop_ok) begin
          r_rptr  <= r_rptr + PTR_W'(1);
          r_pix_r <= {w_head[15:11], w_head[15:13]};
          r_pix_g <= {w_head[10:5],  w_head[10:9]};
          r_pix_b <= {w_head[4:0],   w_head[4:2]};
        end
        if (w_uflow) begin
          r_pix_r     <= '0;
          r_pix_g     <= '0;
          r_pix_b     <= '0;
          r_underflow <= 1'b1;
        end
        r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop_ok);
      end
    end
  end

`ifdef VGA_ARB_UNDERFLOW_CNT_EN
  logic [15:0] r_uflow_cnt;

  // Survives frame starts; only reset clears it.
  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_uflow_cnt <= '0;
    end else if (w_uflow && (r_uflow_cnt != 16'hFFFF)) begin
      r_uflow_cnt <= r_uflow_cnt + 16'd1;
    end
  end

  assign o_underflow_cnt = r_uflow_cnt;
`else
  assign o_underflow_cnt = 16'h0000;
`endif

  assign o_pix_r      = r_pix_r;
  assign o_pix_g      = r_pix_g;
  assign o_pix_b      = r_pix_b;
  assign o_fifo_level = r_level;
  assign o_frame_done = r_frame_done;
  assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 16x4 frame with a behavioural SRAM responder.
module tb_vga_fb_arbiter;

  localparam int CLK_HALF = 20;

`ifdef VGA_ARB_UNDERFLOW_CNT_EN
  localparam logic [15:0] EXP_UCNT = 16'd3;
`else
  localparam logic [15:0] EXP_UCNT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        pix_rd;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [4:0]  fifo_level;
  logic        frame_done;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic        wr_valid;
  logic        wr_ready;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [19:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = 16'h0000;

  logic [15:0] sram [64];
  logic [19:0] rd_log [512];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rd_at_wr = 0;
  int          cyc = 0;
  int          rd63_cyc = 0;
  int          fd_cyc = 0;
  logic        fd_prev = 1'b0;
  logic [19:0] last_rd_addr = '0;
  logic [19:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  int n_total = 0;
  int n_bad   = 0;

  vga_fb_arbiter #(.H_ACT(16), .V_ACT(4)) dut (
    .i_clk_25M       (clk),
    .i_rst_n         (rst_n),
    .i_frame_start   (frame_start),
    .i_pix_rd        (pix_rd),
    .o_pix_r         (pix_r),
    .o_pix_g         (pix_g),
    .o_pix_b         (pix_b),
    .o_fifo_level    (fifo_level),
    .o_frame_done    (frame_done),
    .o_underflow     (underflow),
    .o_underflow_cnt (underflow_cnt),
    .i_wr_valid      (wr_valid),
    .o_wr_ready      (wr_ready),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .o_sram_addr     (sram_addr),
    .o_sram_we_n     (sram_we_n),
    .o_sram_oe_n     (sram_oe_n),
    .o_sram_wdata    (sram_wdata),
    .i_sram_rdata    (sram_rdata)
  );

  always #CLK_HALF clk = ~clk;

  // SRAM responder and bus monitor: data returns one cycle after a read issue.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    fd_prev <= frame_done;
    if (frame_done && !fd_prev) fd_cyc <= cyc;
    if (!sram_oe_n) begin
      rd_log[rd_cnt[8:0]] <= sram_addr;
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= sram_addr;
      sram_rdata   <= sram[sram_addr[5:0]];
      if (sram_addr == 20'd63) rd63_cyc <= cyc;
    end
    if (!sram_we_n) begin
      wr_cnt       <= wr_cnt + 1;
      rd_at_wr     <= rd_cnt;
      last_wr_addr <= sram_addr;
      last_wr_data <= sram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          base;
    int          base_wr;
    logic        seen;
    logic [23:0] want;

    rst_n = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 64; i++)
      sram[i] = (i < 16) ? 16'hF800 : (16'(i * 16'h1357) ^ 16'h2A6B);
    sram[16] = 16'h07E0;
    sram[17] = 16'h001F;
    sram[18] = 16'hB4AD;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pix",   {8'h00, pix_r, pix_g, pix_b}, 32'h0);
    check("rst_level", fifo_level, 0);
    check("rst_flags", {frame_done, underflow, wr_ready}, 3'b000);
    check("rst_cnt",   underflow_cnt, 0);
    check("rst_strb",  {sram_we_n, sram_oe_n}, 2'b11);
    check("rst_bus",   {sram_addr, sram_wdata}, 36'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("disarmed_rd", rd_cnt, 0);

    // Test 1: prefetch fills FIFO with exactly 16 reads
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    repeat (25) @(negedge clk);
    check("t1_nrd", rd_cnt, 16);
    for (int i = 0; i < 16; i++) check("t1_addr", rd_log[i], i);
    check("t1_level", fifo_level, 16);
    check("t1_fdone", frame_done, 0);
    check("t1_oe_idle", sram_oe_n, 1);

    // Test 2: one pop of F800
    base = rd_cnt;
    pix_rd = 1'b1;
    @(negedge clk) pix_rd = 1'b0;
    check("t2_pix", {pix_r, pix_g, pix_b}, 24'hFF0000);
    check("t2_level", fifo_level, 15);
    repeat (4) @(negedge clk);
    check("t2_nrd", rd_cnt - base, 1);
    check("t2_addr", last_rd_addr, 16);
    check("t2_refill", fifo_level, 16);

    // Test 3: write slot with FIFO above watermark
    base_wr = wr_cnt;
    wr_addr = 20'h96000; wr_data = 16'h07E0; wr_valid = 1'b1; pix_rd = 1'b1;
    @(negedge clk);
    check("t3_wr_strb",  {sram_we_n, sram_oe_n, wr_ready}, 3'b011);
    check("t3_wr_addr",  sram_addr, 20'h96000);
    check("t3_wr_data",  sram_wdata, 16'h07E0);
    check("t3_wr_level", fifo_level, 15);
    wr_valid = 1'b0;
    @(negedge clk);
    check("t3_turn",       {sram_we_n, sram_oe_n, wr_ready}, 3'b110);
    check("t3_turn_level", fifo_level, 14);
    @(negedge clk);
    check("t3_resume_oe",   sram_oe_n, 0);
    check("t3_resume_addr", sram_addr, 17);
    check("t3_resume_lvl",  fifo_level, 13);
    pix_rd = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_nwr",     wr_cnt - base_wr, 1);
    check("t3_wr_seen", {last_wr_addr, last_wr_data}, {20'h96000, 16'h07E0});
    check("t3_level",   fifo_level, 16);

    // Test 3b: below watermark reads beat a pending write
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    base = rd_cnt; base_wr = wr_cnt;
    wr_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (wr_ready) begin
        seen = 1'b1;
        wr_valid = 1'b0;
      end
    end
    check("wm_grant", seen, 1);
    repeat (30) @(negedge clk);
    check("wm_rd_before_wr", rd_at_wr - base, 8);
    check("wm_nrd", rd_cnt - base, 16);
    check("wm_nwr", wr_cnt - base_wr, 1);
    check("wm_level", fifo_level, 16);

    // Test 4: full frame, pop every cycle once the FIFO is full
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    base = rd_cnt;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (fifo_level == 5'd16) seen = 1'b1;
    end
    check("t4_fill", seen, 1);
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (i - 1 < 16)       want = 24'hFF0000;
        else if (i - 1 == 16) want = 24'h00FF00;
        else if (i - 1 == 17) want = 24'h0000FF;
        else if (i - 1 == 18) want = 24'hB5966B;
        else                  want = exp_pix(sram[i - 1]);
        check("t4_pix", {pix_r, pix_g, pix_b}, want);
      end
      pix_rd = (i < 64);
    end
    repeat (4) @(negedge clk);
    check("t4_nrd", rd_cnt - base, 64);
    check("t4_fdone", frame_done, 1);
    check("t4_fdone_lat", fd_cyc - rd63_cyc, 1);
    check("t4_no_uflow", underflow, 0);
    check("t4_level", fifo_level, 0);

    // Test 5: three pops on an empty FIFO
    pix_rd = 1'b1;
    @(negedge clk);
    check("t5_pix", {pix_r, pix_g, pix_b}, 24'h000000);
    check("t5_uflow", underflow, 1);
    repeat (2) @(negedge clk);
    pix_rd = 1'b0;
    check("t5_cnt", underflow_cnt, EXP_UCNT);
    frame_start = 1'b1;

    // Test 6: frame start clears flags, then squashes an in-flight read
    @(negedge clk) frame_start = 1'b0;
    #1;
    check("t6_uflow_clr", underflow, 0);
    check("t6_cnt_kept", underflow_cnt, EXP_UCNT);
    check("t6_fdone_clr", frame_done, 0);
    check("t6_rd0", {sram_oe_n, sram_addr}, {1'b0, 20'h0});
    @(negedge clk) frame_start = 1'b1;
    #1;
    check("t6_no_rd", sram_oe_n, 1);
    @(negedge clk) frame_start = 1'b0;
    #1;
    check("t6_squash_lvl", fifo_level, 0);
    check("t6_restart", {sram_oe_n, sram_addr}, {1'b0, 20'h0});

    // Reset during a write cycle
    repeat (25) @(negedge clk);
    wr_addr = 20'h12345; wr_data = 16'hBEEF; wr_valid = 1'b1;
    @(negedge clk);
    check("rw_strobe", sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rw_strb_off", {sram_we_n, sram_oe_n, wr_ready}, 3'b110);
    check("rw_level", fifo_level, 0);
    check("rw_cnt", underflow_cnt, 0);
    base = rd_cnt;
    @(negedge clk) wr_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rw_disarmed", rd_cnt - base, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
